change_monitor: RTL
===================

# change_monitor

Hardware counterpart to the simulator's `$monitor` system task. It watches a net driven by continuous assignments and records each value change with a cycle timestamp. Records are buffered in a FIFO and drained by a downstream reader over a valid/ready handshake. It sits beside the assignment-test datapaths as the observation end: they write the net, this block reads it back as a change log.

## Interface
- `DATA_W`, 8, width of the watched net.
- `TS_W`, 16, width of the timestamp counter.
- `DEPTH`, 8, number of FIFO entries; a power of two, ≥ 2.

- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: monitoring on while high.
- `watch` input DATA_W: the observed net.
- `clear` input 1: single-cycle pulse that clears `overflow` and `drop_cnt`.
- `out_valid` output 1: a FIFO head record is present.
- `out_ready` input 1: the reader accepts the head record.
- `out_ts` output TS_W: timestamp of the head record.
- `out_data` output DATA_W: value of the head record.
- `overflow` output 1: sticky flag, set when any record was dropped.
- `drop_cnt` output 8: number of dropped records, saturates at 255.

## Operation
- `ts` is a free-running counter that increments every cycle and wraps from 2^TS_W−1 to 0. It runs regardless of `enable`.
- The FSM has three states:
  - IDLE: `enable` low; nothing is captured. Go to PRIME when `enable` is high.
  - PRIME: capture `{ts, watch}` unconditionally, which is the initial record, as `$monitor` prints first. Load `prev` with `watch`. Go to RUN, or to IDLE if `enable` is low.
  - RUN: when `watch != prev`, capture `{ts, watch}` and set `prev` to `watch`. Go to IDLE when `enable` is low; that cycle captures nothing.
- A re-enable always passes through PRIME, so it always produces an initial record.
- At most one record per cycle. A change that reverts within the same cycle is invisible, because sampling happens only at clock edges.
- Push when full with no pop: the record is dropped, `overflow` is set to 1, and `drop_cnt` increments, saturating at 255.
- Push and pop in the same cycle while full: both happen, the record is accepted, and the count is unchanged.
- Push and pop in the same cycle while empty: the pop is impossible because `out_valid` is 0, so only the push happens.
- Same-cycle `clear` and drop: the drop wins, giving `overflow` = 1 and `drop_cnt` = 1.
- The FIFO is first-word-fall-through. `out_ts` and `out_data` show the head entry and are driven to 0 while `out_valid` is 0.
- Handshake: a transfer occurs on a clock edge where `out_valid` and `out_ready` are both high. While `out_valid` is high and `out_ready` is low, `out_ts` and `out_data` hold stable. `out_valid` never drops without a transfer, except on reset.

## Timing
- Reset values:
  - FSM state IDLE.
  - `ts`, `prev`, FIFO pointers and count all 0.
  - `out_valid`, `overflow` 0; `drop_cnt` 0.
  - `out_ts`, `out_data` 0.
- `ts` is 0 in the first cycle after `rst_n` deasserts.
- A record stores the `ts` value present before the capturing edge.
- Latency: when `watch` changes before edge N, the record is written at edge N. If the FIFO was empty, `out_valid` is high in the cycle after edge N.
- Reset asserted mid-operation immediately empties the FIFO. In-flight records are lost and are not counted as drops.
- `enable` is sampled at edges like any other input. The `enable` 0→1 edge takes one cycle to PRIME, so the initial record's `ts` is the value at the PRIME cycle.

## Structure
- Package `change_monitor_pkg` holds:
  - the state enum `{IDLE, PRIME, RUN}`;
  - the function computing record width (TS_W+DATA_W);
  - `DROP_MAX` = 255.
- Sub-module `change_fifo`: a synchronous FWFT FIFO parameterised by width and depth. It exposes push, pop, full, empty and head data, using pointers that are log2(DEPTH)+1 bits wide.
- The top level contains the FSM, the `ts` counter, the change comparator and the drop accounting.

## Test plan
- Reset release with `enable`=1 and `watch`=0 at the first post-reset cycle (`ts`=0) → PRIME follows at `ts`=1 → one record {1, 0}. `watch` then held constant for 20 cycles → no further records.
- `watch` steps 0→1 before edge 5 and 1→3 before edge 8, reader always ready → records {5,1} and {8,3}, each visible one cycle after its edge.
- `out_ready`=0 with DEPTH=8, 10 changes → 8 records kept, `overflow`=1, `drop_cnt`=2. Draining then returns the first 8 records in order with unchanged data.
- FIFO full, a change and `out_ready`=1 in the same cycle → no drop, count stays 8, `drop_cnt` unchanged.
- TS_W=4, a change at `ts`=15 and another at `ts`=0 → stored timestamps are 15 then 0, showing wrap.
- `rst_n` pulsed low mid-stream with 3 records queued → `out_valid`=0 and `drop_cnt`=0 immediately. After release, a PRIME record appears.

Source files
------------

// File: rtl/change_monitor_pkg.sv
// change_monitor_pkg: shared types and constants for the change monitor.
//   mon_state_e : monitor FSM states
//   DROP_MAX    : saturation value of the dropped-record counter
//   rec_width() : width of one {timestamp, value} record
package change_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } mon_state_e;

    localparam logic [7:0] DROP_MAX = 8'd255;

    function automatic int rec_width(input int ts_w, input int data_w);
        return ts_w + data_w;
    endfunction

endpackage

// File: rtl/change_fifo.sv
// change_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push       : write push_data this cycle (accepted when not full, or
//                when full and a pop happens in the same cycle)
//   pop        : remove the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head_data  : current head entry, valid while empty is low
module change_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and the effective push/pop qualifiers.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        head_data = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/change_monitor.sv
// change_monitor: records every value change of a watched net with a cycle
// timestamp and queues the records for a downstream reader.
//   clk, rst_n          : clock, async active-low reset
//   enable              : monitoring on while high
//   watch               : observed net
//   clear               : pulse clearing overflow and drop_cnt
//   out_valid/out_ready : valid/ready handshake on the head record
//   out_ts, out_data    : head record, forced to 0 while out_valid is low
//   overflow            : sticky, set when a record was dropped
//   drop_cnt            : dropped records, saturating at 255
module change_monitor
    import change_monitor_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] watch,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W-1:0]   out_ts,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int REC_W = rec_width(TS_W, DATA_W);

    mon_state_e        state_r;
    logic [TS_W-1:0]   ts_r;
    logic [DATA_W-1:0] prev_r;
    logic              overflow_r;
    logic [7:0]        drop_cnt_r;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              full_s;
    logic              empty_s;
    logic [REC_W-1:0]  head_s;

    // Free-running timestamp, independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // Monitor FSM. PRIME always loads prev so a re-enable starts a fresh log.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            prev_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= enable ? PRIME : IDLE;
                end
                PRIME: begin
                    prev_r  <= watch;
                    state_r <= enable ? RUN : IDLE;
                end
                RUN: begin
                    if (!enable) begin
                        state_r <= IDLE;
                    end else if (watch != prev_r) begin
                        prev_r <= watch;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Capture decision, handshake and drop detection.
    always_comb begin
        case (state_r)
            PRIME:   push_s = 1'b1;
            RUN:     push_s = enable && (watch != prev_r);
            default: push_s = 1'b0;
        endcase
        pop_s  = !empty_s && out_ready;
        drop_s = push_s && full_s && !pop_s;
    end

    // Drop accounting; a drop in the same cycle as clear restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (clear) begin
                drop_cnt_r <= 8'd1;
            end else if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end else if (clear) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end
    end

    change_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({ts_r, watch}),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .head_data (head_s)
    );

    // Outputs come straight from registered state; the head is masked while empty.
    always_comb begin
        out_valid = !empty_s;
        if (empty_s) begin
            {out_ts, out_data} = {REC_W{1'b0}};
        end else begin
            {out_ts, out_data} = head_s;
        end
        overflow = overflow_r;
        drop_cnt = drop_cnt_r;
    end

endmodule
